// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles, branch flush,
// data-memory freeze and a memory watchdog. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int WAIT_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              freeze_s;
  logic              lu_s;

  assign freeze_s = mem_req & ~mem_ready;
  assign lu_s     = ex_mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= {WAIT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Watchdog next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (freeze_s) begin
          if (TIMEOUT == 1) begin
            state_d = ST_HALT;
            wait_d  = {WAIT_W{1'b0}};
          end else begin
            state_d = ST_MEM_WAIT;
            wait_d  = {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_RUN;
          wait_d  = {WAIT_W{1'b0}};
        end
      end
      ST_MEM_WAIT: begin
        if (!freeze_s) begin
          state_d = ST_RUN;
          wait_d  = {WAIT_W{1'b0}};
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
          wait_d  = wait_q;
        end else begin
          state_d = ST_MEM_WAIT;
          wait_d  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
        wait_d  = wait_q;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Pipeline controls: halt > freeze > load-use > branch > run; reset forces run
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    if (rst) begin
      halted = 1'b0;
    end else if (state_q == ST_HALT) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      halted        = 1'b1;
    end else if (freeze_s) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (lu_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end else begin
      halted = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, freeze_cnt_q, flush_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q     <= {CNT_W{1'b0}};
      freeze_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      if (id_ex_bubble && (lu_cnt_q != {CNT_W{1'b1}})) begin
        lu_cnt_q <= lu_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (freeze_s && (state_q != ST_HALT) && (freeze_cnt_q != {CNT_W{1'b1}})) begin
        freeze_cnt_q <= freeze_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign freeze_cnt   = freeze_cnt_q;
  assign flush_cnt    = flush_cnt_q;
`else
  assign lu_stall_cnt = {CNT_W{1'b0}};
  assign freeze_cnt   = {CNT_W{1'b0}};
  assign flush_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4); counter expectations
// follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic        ex_mem_write, mem_wb_bubble, halted;
  logic [15:0] lu_stall_cnt, freeze_cnt, flush_cnt;
  logic [7:0]  ctrl_s;

  int checks_n = 0;
  int fails_n  = 0;

  // {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, mwb_bubble, halted}
  localparam logic [7:0] RUN_V  = 8'b1101_0100;
  localparam logic [7:0] LU_V   = 8'b0001_1100;
  localparam logic [7:0] BR_V   = 8'b1111_0100;
  localparam logic [7:0] FRZ_V  = 8'b0000_0010;
  localparam logic [7:0] HALT_V = 8'b0000_0011;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .WAIT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted),
    .lu_stall_cnt(lu_stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl_s = {pc_write, if_id_write, if_id_flush, id_ex_write,
                   id_ex_bubble, ex_mem_write, mem_wb_bubble, halted};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_n++;
    if (obs !== exp_v) begin
      fails_n++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] pexp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic check_cnts(input string tag, input int lu, input int frz, input int fl);
    check_eq({tag, "_lu_cnt"}, {16'd0, lu_stall_cnt}, pexp(lu));
    check_eq({tag, "_frz_cnt"}, {16'd0, freeze_cnt}, pexp(frz));
    check_eq({tag, "_flush_cnt"}, {16'd0, flush_cnt}, pexp(fl));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    mem_req = 1'b1;
    #1;
    check_eq("rst_force", {24'd0, ctrl_s}, {24'd0, RUN_V});
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check_eq("idle", {24'd0, ctrl_s}, {24'd0, RUN_V});
    check_cnts("reset", 0, 0, 0);

    // Load-use on rs
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    check_eq("lu_rs", {24'd0, ctrl_s}, {24'd0, LU_V});
    tick();
    ex_mem_read = 1'b0;
    #1;
    check_eq("lu_after", {24'd0, ctrl_s}, {24'd0, RUN_V});
    check_eq("lu_cnt1", {16'd0, lu_stall_cnt}, pexp(1));

    // $zero destination and unused rt
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    check_eq("lu_zero", {24'd0, ctrl_s}, {24'd0, RUN_V});
    tick();
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    check_eq("lu_rt_unused", {24'd0, ctrl_s}, {24'd0, RUN_V});
    tick();
    id_uses_rt = 1'b1;
    #1;
    check_eq("lu_rt_used", {24'd0, ctrl_s}, {24'd0, LU_V});
    tick();

    // Load-use outranks branch, then branch alone flushes
    ex_rt = 5'd9; id_rs = 5'd9; id_rt = 5'd1; id_uses_rt = 1'b0; branch_taken = 1'b1;
    #1;
    check_eq("prio_lu_br", {24'd0, ctrl_s}, {24'd0, LU_V});
    tick();
    ex_mem_read = 1'b0;
    #1;
    check_eq("branch", {24'd0, ctrl_s}, {24'd0, BR_V});
    tick();
    branch_taken = 1'b0;
    #1;
    check_cnts("after_br", 3, 0, 1);

    // Three-cycle memory wait; lu/branch ignored while frozen
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; branch_taken = 1'b1;
      end else begin
        ex_mem_read = 1'b0; branch_taken = 1'b0;
      end
      #1;
      check_eq($sformatf("freeze%0d", i), {24'd0, ctrl_s}, {24'd0, FRZ_V});
      tick();
    end
    ex_mem_read = 1'b0; branch_taken = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("mem_ready", {24'd0, ctrl_s}, {24'd0, RUN_V});
    check_cnts("after_wait", 3, 3, 1);
    tick();

    // Watchdog: four consecutive freeze cycles halt the core
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("wd_freeze%0d", i), {24'd0, ctrl_s}, {24'd0, FRZ_V});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("halt_c5", {24'd0, ctrl_s}, {24'd0, HALT_V});
    tick();
    mem_ready = 1'b0; branch_taken = 1'b1;
    #1;
    check_eq("halt_sticky", {24'd0, ctrl_s}, {24'd0, HALT_V});
    tick();
    branch_taken = 1'b0;
    #1;
    check_cnts("halted", 3, 7, 1);

    // Reset releases the halt
    rst = 1'b1;
    #1;
    check_eq("rst_halt", {24'd0, ctrl_s}, {24'd0, RUN_V});
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check_eq("post_rst", {24'd0, ctrl_s}, {24'd0, RUN_V});
    check_cnts("post_rst", 0, 0, 0);

    // Reset mid-wait; the following wait counts from one
    mem_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst_midwait", {24'd0, ctrl_s}, {24'd0, RUN_V});
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rw_freeze%0d", i), {24'd0, ctrl_s}, {24'd0, FRZ_V});
      tick();
    end
    #1;
    check_eq("rw_halt", {24'd0, ctrl_s}, {24'd0, HALT_V});
    check_eq("rw_frz_cnt", {16'd0, freeze_cnt}, pexp(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage pipelined MIPS core. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Generates their write-enable, flush and bubble controls from three sources:
- load-use dependencies;
- taken branches resolved in ID;
- a multi-cycle data-memory handshake.

It also contains a watchdog that halts the core if memory never answers.

## Interface
Parameters:
- TIMEOUT, 255 — consecutive memory-wait cycles before the core halts; legal range 1..2^WAIT_W-1.
- WAIT_W, 8 — width of the wait counter.
- CNT_W, 16 — width of the performance counters.

Ports:
- clk  in  1  — core clock.
- rst  in  1  — reset; one clock, synchronous, active-high.
- id_rs  in  5  — rs field of the instruction in ID.
- id_rt  in  5  — rt field of the instruction in ID.
- id_uses_rt  in  1  — the instruction in ID reads rt.
- ex_mem_read  in  1  — the instruction in EX is a load (ID/EX M-control bit).
- ex_rt  in  5  — load destination register in EX.
- branch_taken  in  1  — branch/jump resolved taken in ID this cycle.
- mem_req  in  1  — the MEM stage is issuing a data-memory access.
- mem_ready  in  1  — data memory completes the access this cycle.
- pc_write  out  1  — PC load enable.
- if_id_write  out  1  — IF/ID load enable.
- if_id_flush  out  1  — IF/ID loads a NOP.
- id_ex_write  out  1  — ID/EX load enable.
- id_ex_bubble  out  1  — ID/EX loads zero M/WB/EX control signals.
- ex_mem_write  out  1  — EX/MEM load enable.
- mem_wb_bubble  out  1  — MEM/WB loads zero WB control signals.
- halted  out  1  — watchdog tripped; sticky until rst.
- lu_stall_cnt  out  CNT_W  — load-use bubble count.
- freeze_cnt  out  CNT_W  — memory freeze cycle count.
- flush_cnt  out  CNT_W  — IF/ID flush count.

## Operation
Conditions, evaluated combinationally each cycle:
- **freeze** = mem_req & !mem_ready.
- **lu** = ex_mem_read & ex_rt != 0 & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).

Output priority, highest first:
1. **HALT state:**
   - All write enables 0.
   - mem_wb_bubble 1.
   - if_id_flush 0.
   - id_ex_bubble 0.
2. **freeze:**
   - pc_write, if_id_write, id_ex_write and ex_mem_write all 0.
   - mem_wb_bubble 1, so WB does not retire the held instruction twice.
   - lu and branch_taken are ignored; they are re-evaluated once the freeze clears.
3. **lu:**
   - pc_write and if_id_write 0.
   - id_ex_bubble 1.
   - id_ex_write and ex_mem_write 1.
   - branch_taken is ignored, because its operands are not yet valid.
4. **branch_taken:** if_id_flush 1, with all enables 1.
5. **Otherwise:** all enables 1, all flush and bubble outputs 0.

FSM, with wait_cnt of WAIT_W bits:
- **RUN** (wait_cnt = 0):
  - On freeze, go to MEM_WAIT with wait_cnt = 1.
  - If TIMEOUT == 1, go to HALT instead.
- **MEM_WAIT:**
  - If !freeze, go to RUN and set wait_cnt = 0.
  - If freeze and wait_cnt == TIMEOUT-1, go to HALT.
  - Otherwise increment wait_cnt.
- **HALT:** absorbing; only rst exits.

Reset:
- rst sets the state to RUN, wait_cnt to 0 and all counters to 0.
- While rst is high, outputs are forced to: all write enables 1, if_id_flush/id_ex_bubble/mem_wb_bubble 0, halted 0.
- rst asserted mid-wait or in HALT returns the block to RUN on the next edge.

## Timing
- All control outputs are combinational from the current state and inputs, with zero latency. They are consumed at the same edge by the pipeline registers.
- A load-use hazard inserts exactly one bubble. On the following cycle EX holds the bubble (ex_mem_read = 0), so lu deasserts without any state.
- Freeze lasts exactly as long as mem_req & !mem_ready. In the cycle mem_ready rises, the enables are 1.
- halted rises on the cycle after the TIMEOUT-th consecutive freeze cycle.
- mem_ready arriving on the TIMEOUT-th cycle itself is not a freeze cycle, so no halt occurs.

## Configuration
Macro HAZARD_PERF_CNT_EN.

When defined, three saturating counters are built. Each holds at 2^CNT_W-1 and is cleared by rst.
- lu_stall_cnt: +1 per cycle where id_ex_bubble = 1.
- freeze_cnt: +1 per freeze cycle outside HALT.
- flush_cnt: +1 per cycle where if_id_flush = 1.

When undefined, the three ports remain present, are tied to 0, and no counter flops are built.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle.
  - Expect pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Next cycle (ex_mem_read=0): all enables 1; lu_stall_cnt=1.
- **$zero and unused rt:** ex_rt=0 with id_rs=0, and ex_rt=7 with id_rt=7 and id_uses_rt=0.
  - Expect no stall in either case.
- **Priority:** branch_taken=1 together with lu=1.
  - Expect no flush and a bubble only.
  - Next cycle, with branch_taken=1 and no lu: if_id_flush=1; flush_cnt=1.
- **Memory wait:** mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Expect 3 cycles with all enables 0 and mem_wb_bubble=1, then enables 1; freeze_cnt=3; state returns to RUN.
- **Watchdog:** TIMEOUT=4, freeze held for 4 cycles.
  - Expect halted=1 from cycle 5, held even after mem_ready=1.
  - Assert rst for 1 cycle: halted=0, enables 1, counters 0.
- **Reset mid-wait:** rst after 2 freeze cycles.
  - Expect RUN; a subsequent freeze counts from wait_cnt=1.
